vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15, framebuffer address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, pixel width in RRRGGGBB format.
REQ-003 The block SHALL have parameter FB_W, default 160, framebuffer columns.
REQ-004 The block SHALL have parameter FB_H, default 120, framebuffer rows.
REQ-005 Port iClk, input, 1 bit: the single clock, rising edge.
REQ-006 Port iRst, input, 1 bit: synchronous active-high reset.
REQ-007 Port iPixelTick, input, 1 bit: pixel strobe from the sync generator.
REQ-008 Port iVideoOn, input, 1 bit: visible-area flag.
REQ-009 Port iPixelX and port iPixelY, inputs, 16 bits each: current pixel coordinates.
REQ-010 Port iWrReq, input, 1 bit: writer request, held with address and data until acknowledged.
REQ-011 Port iWrAddr, input, ADDR_W bits: writer address.
REQ-012 Port iWrData, input, DATA_W bits: writer data.
REQ-013 Port oWrAck, output, 1 bit: one-cycle write acknowledge.
REQ-014 Port oMemEn and port oMemWe, outputs, 1 bit each: single-port RAM enable and write enable.
REQ-015 Port oMemAddr, output, ADDR_W bits, and port oMemWData, output, DATA_W bits: RAM address and write data.
REQ-016 Port iMemRData, input, DATA_W bits: RAM read data, valid one clock after the enabled read.
REQ-017 Port oRGB, output, DATA_W bits: pixel colour to the DAC.
REQ-018 Port oAddrErr, output, 1 bit: sticky out-of-range write flag.

Function
REQ-019 Arbitration SHALL be evaluated every cycle in strict priority order: display read, then write, then idle.
REQ-020 A display slot SHALL occur when iPixelTick=1 and iVideoOn=1, with read address = (iPixelY>>2)*FB_W + (iPixelX>>2), truncated to ADDR_W.
REQ-021 A write SHALL be granted when iWrReq=1, there is no display slot, and oWrAck=0 in the current cycle, so that a write is never granted back-to-back to the same request.
REQ-022 The FSM SHALL have states ST_IDLE, ST_RD and ST_WR, entered in the cycle after the respective grant (ST_IDLE when nothing is granted).
REQ-023 All RAM-port outputs SHALL be registered: ST_RD drives oMemEn=1 and oMemWe=0; ST_WR drives oMemEn=1 and oMemWe=1; ST_IDLE drives both to 0.
REQ-024 oWrAck SHALL be 1 exactly in the ST_WR cycle.
REQ-025 Read latency: a tick in cycle N SHALL cause oMemEn in N+1, iMemRData to be sampled at the end of N+2, and oRGB to update in N+3.
REQ-026 oRGB SHALL hold its value between reads.
REQ-027 iVideoOn SHALL be delayed three cycles alongside the read, and oRGB SHALL be 0 while the delayed flag is 0.
REQ-028 A write with iWrAddr >= FB_W*FB_H SHALL still be acknowledged, with oMemEn=0 and oMemWe=0 in that cycle, and SHALL set oAddrErr until reset.
REQ-029 Display reads SHALL never be delayed or dropped by writer activity.
REQ-030 A write request SHALL wait indefinitely while display slots occupy every cycle.
REQ-031 When a tick and a request arrive in the same cycle, the tick SHALL win and the write SHALL be granted at the next free cycle.

Reset
REQ-032 While iRst=1, the block SHALL force the FSM to ST_IDLE and drive oMemEn=0, oMemWe=0, oMemAddr=0, oMemWData=0, oWrAck=0, oRGB=0 and oAddrErr=0, and clear the video-on delay line.
REQ-033 Reset asserted mid-operation SHALL abort any in-flight read or write, SHALL issue no acknowledge, and SHALL NOT re-issue the aborted request automatically.

Configuration
REQ-034 With macro VGA_FB_BLANK_WR_EN defined, writes SHALL be granted only while iVideoOn=0, for tear-free updates.
REQ-035 Without VGA_FB_BLANK_WR_EN, writes SHALL be granted in any cycle with no display slot.

Verification
REQ-036 Reset then tick with X=8, Y=4 and video on -> oMemEn=1, oMemWe=0, oMemAddr=162 one cycle later; RAM returns 0xE3 -> oRGB=0xE3 three cycles after the tick.
REQ-037 iWrReq with addr 0x0010 and data 0x1C on an idle bus -> next cycle ST_WR with oMemWe=1, oMemAddr=0x0010, oMemWData=0x1C, oWrAck=1; no second write while the request is still high in that cycle.
REQ-038 Tick and iWrReq in the same cycle -> read issued first, write in the following cycle, ack two cycles after the request.
REQ-039 Write to addr 19200 -> oWrAck=1, oMemEn=0, oAddrErr=1 and held until iRst.
REQ-040 iRst asserted in the ST_WR cycle -> the cycle after it has oWrAck=0 and oMemEn=0, and oRGB=0.
REQ-041 With VGA_FB_BLANK_WR_EN defined: request during iVideoOn=1 -> no ack until iVideoOn falls, then ack within 2 cycles.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between the display
// scan-out (strict priority, fixed three-cycle latency to oRGB) and a writer
// that holds iWrReq/iWrAddr/iWrData until oWrAck.
// Optional build macro VGA_FB_BLANK_WR_EN: writes are granted only while
// iVideoOn=0, so frame updates land in blanking and never tear.
module vga_fb_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int FB_W   = 160,
    parameter int FB_H   = 120
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iPixelTick,
    input  logic              iVideoOn,
    input  logic [15:0]       iPixelX,
    input  logic [15:0]       iPixelY,
    input  logic              iWrReq,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    output logic              oWrAck,
    output logic              oMemEn,
    output logic              oMemWe,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    input  logic [DATA_W-1:0] iMemRData,
    output logic [DATA_W-1:0] oRGB,
    output logic              oAddrErr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic              slot;
    logic              wrAllowed;
    logic              grantRd;
    logic              grantWr;
    logic              wrBad;
    logic              wrBad_p0;
    logic [ADDR_W-1:0] rdAddr;
    logic              vidOn_p0;
    logic              vidOn_p1;
    logic              vidOn_p2;
    logic              rdVld_p1;
    logic [DATA_W-1:0] rgbHold;

    // The framebuffer is quarter resolution: each RAM cell covers a 4x4 block.
    assign rdAddr = ADDR_W'(iPixelY >> 2) * ADDR_W'(FB_W) + ADDR_W'(iPixelX >> 2);
    assign wrBad  = 32'(iWrAddr) >= 32'(FB_W * FB_H);
    assign slot   = iPixelTick & iVideoOn;

`ifdef VGA_FB_BLANK_WR_EN
    assign wrAllowed = ~iVideoOn;
`else
    assign wrAllowed = 1'b1;
`endif

    // Display always wins; the ack term stops one held request being written twice.
    assign grantRd = slot;
    assign grantWr = iWrReq & ~slot & ~oWrAck & wrAllowed;

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) state <= ST_IDLE;
        else      state <= stateNext;
    end

    // Next-state decode from this cycle's grants.
    always_comb begin
        stateNext = ST_IDLE;
        if (grantRd)      stateNext = ST_RD;
        else if (grantWr) stateNext = ST_WR;
    end

    // RAM strobes and ack decoded from the state flop; an out-of-range write is acked but kept off the RAM.
    always_comb begin
        oMemEn = 1'b0;
        oMemWe = 1'b0;
        oWrAck = 1'b0;
        case (state)
            ST_RD: oMemEn = 1'b1;
            ST_WR: begin
                oMemEn = ~wrBad_p0;
                oMemWe = ~wrBad_p0;
                oWrAck = 1'b1;
            end
            default: ;
        endcase
    end

    // Grant stage -> RAM port stage: capture address/data of the granted access.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oMemAddr  <= '0;
            oMemWData <= '0;
            wrBad_p0  <= 1'b0;
        end else if (grantRd) begin
            oMemAddr  <= rdAddr;
        end else if (grantWr) begin
            oMemAddr  <= iWrAddr;
            oMemWData <= iWrData;
            wrBad_p0  <= wrBad;
        end
    end

    // Sticky error flag, set by any granted out-of-range write.
    always_ff @(posedge iClk) begin
        if (iRst)                  oAddrErr <= 1'b0;
        else if (grantWr && wrBad) oAddrErr <= 1'b1;
    end

    // Video-on delay line, matched to the three-cycle read path.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            vidOn_p0 <= 1'b0;
            vidOn_p1 <= 1'b0;
            vidOn_p2 <= 1'b0;
        end else begin
            vidOn_p0 <= iVideoOn;
            vidOn_p1 <= vidOn_p0;
            vidOn_p2 <= vidOn_p1;
        end
    end

    // RAM port stage -> read-data stage -> pixel hold register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            rdVld_p1 <= 1'b0;
            rgbHold  <= '0;
        end else begin
            rdVld_p1 <= (state == ST_RD);
            if (rdVld_p1) rgbHold <= iMemRData;
        end
    end

    assign oRGB = vidOn_p2 ? rgbHold : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter (default build, blank-only writes disabled).
module tb_vga_fb_arbiter;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iPixelTick;
    logic        iVideoOn;
    logic [15:0] iPixelX;
    logic [15:0] iPixelY;
    logic        iWrReq;
    logic [14:0] iWrAddr;
    logic [7:0]  iWrData;
    logic        oWrAck;
    logic        oMemEn;
    logic        oMemWe;
    logic [14:0] oMemAddr;
    logic [7:0]  oMemWData;
    logic [7:0]  iMemRData;
    logic [7:0]  oRGB;
    logic        oAddrErr;

    int nVec = 0;
    int nErr = 0;

    always #5 iClk = ~iClk;

    vga_fb_arbiter dut (
        .iClk(iClk), .iRst(iRst), .iPixelTick(iPixelTick), .iVideoOn(iVideoOn),
        .iPixelX(iPixelX), .iPixelY(iPixelY), .iWrReq(iWrReq), .iWrAddr(iWrAddr),
        .iWrData(iWrData), .oWrAck(oWrAck), .oMemEn(oMemEn), .oMemWe(oMemWe),
        .oMemAddr(oMemAddr), .oMemWData(oMemWData), .iMemRData(iMemRData),
        .oRGB(oRGB), .oAddrErr(oAddrErr)
    );

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        iRst = 1'b1; iPixelTick = 1'b0; iVideoOn = 1'b0; iPixelX = '0; iPixelY = '0;
        iWrReq = 1'b0; iWrAddr = '0; iWrData = '0; iMemRData = '0;
        step(); step();
        chk("rst_memEn", 32'(oMemEn), 32'd0);
        chk("rst_memWe", 32'(oMemWe), 32'd0);
        chk("rst_memAddr", 32'(oMemAddr), 32'd0);
        chk("rst_wData", 32'(oMemWData), 32'd0);
        chk("rst_ack", 32'(oWrAck), 32'd0);
        chk("rst_rgb", 32'(oRGB), 32'd0);
        chk("rst_addrErr", 32'(oAddrErr), 32'd0);
        iRst = 1'b0;
        step();

        // tick with video off is not a display slot
        iPixelTick = 1'b1;
        step();
        iPixelTick = 1'b0;
        chk("tick_blank_noEn", 32'(oMemEn), 32'd0);

        // display read at X=8,Y=4 -> addr 1*160+2 = 162, data back 3 cycles after tick
        iVideoOn = 1'b1; iPixelTick = 1'b1; iPixelX = 16'd8; iPixelY = 16'd4;
        step();
        iPixelTick = 1'b0;
        chk("rd_memEn", 32'(oMemEn), 32'd1);
        chk("rd_memWe", 32'(oMemWe), 32'd0);
        chk("rd_memAddr", 32'(oMemAddr), 32'd162);
        chk("rd_noAck", 32'(oWrAck), 32'd0);
        iMemRData = 8'hE3;
        step();
        chk("rd_idleAfter", 32'(oMemEn), 32'd0);
        step();
        chk("rd_rgb", 32'(oRGB), 32'hE3);
        iMemRData = 8'h55;
        step();
        chk("rgb_hold", 32'(oRGB), 32'hE3);

        // video off blanks oRGB three cycles later
        iVideoOn = 1'b0;
        step(); step();
        chk("rgb_blankLag", 32'(oRGB), 32'hE3);
        step();
        chk("rgb_blank", 32'(oRGB), 32'd0);

        // write on idle bus, request held through the ack cycle
        iWrReq = 1'b1; iWrAddr = 15'h0010; iWrData = 8'h1C;
        step();
        chk("wr_memEn", 32'(oMemEn), 32'd1);
        chk("wr_memWe", 32'(oMemWe), 32'd1);
        chk("wr_memAddr", 32'(oMemAddr), 32'h10);
        chk("wr_wData", 32'(oMemWData), 32'h1C);
        chk("wr_ack", 32'(oWrAck), 32'd1);
        step();
        iWrReq = 1'b0;
        chk("wr_noRepeatAck", 32'(oWrAck), 32'd0);
        chk("wr_noRepeatWe", 32'(oMemWe), 32'd0);
        step();

        // tick and request together: read first, write next
        iVideoOn = 1'b1; iPixelTick = 1'b1; iPixelX = 16'd0; iPixelY = 16'd0;
        iWrReq = 1'b1; iWrAddr = 15'h0020; iWrData = 8'h33;
        step();
        iPixelTick = 1'b0; iVideoOn = 1'b0;
        chk("col_rdEn", 32'(oMemEn), 32'd1);
        chk("col_rdWe", 32'(oMemWe), 32'd0);
        chk("col_rdAddr", 32'(oMemAddr), 32'd0);
        chk("col_noAckYet", 32'(oWrAck), 32'd0);
        step();
        iWrReq = 1'b0;
        chk("col_wrAck", 32'(oWrAck), 32'd1);
        chk("col_wrWe", 32'(oMemWe), 32'd1);
        chk("col_wrAddr", 32'(oMemAddr), 32'h20);
        chk("col_wData", 32'(oMemWData), 32'h33);
        step();

        // out-of-range write: acked, RAM untouched, sticky error
        iWrReq = 1'b1; iWrAddr = 15'd19200; iWrData = 8'hAA;
        step();
        iWrReq = 1'b0;
        chk("oor_ack", 32'(oWrAck), 32'd1);
        chk("oor_memEn", 32'(oMemEn), 32'd0);
        chk("oor_memWe", 32'(oMemWe), 32'd0);
        chk("oor_err", 32'(oAddrErr), 32'd1);
        step(); step();
        chk("oor_errSticky", 32'(oAddrErr), 32'd1);

        // last legal address is accepted
        iWrReq = 1'b1; iWrAddr = 15'd19199; iWrData = 8'h01;
        step();
        iWrReq = 1'b0;
        chk("edge_memEn", 32'(oMemEn), 32'd1);
        chk("edge_memWe", 32'(oMemWe), 32'd1);
        step();

        // reset in the write cycle aborts it
        iWrReq = 1'b1; iWrAddr = 15'd5; iWrData = 8'h01;
        step();
        chk("abort_ackBefore", 32'(oWrAck), 32'd1);
        iRst = 1'b1; iWrReq = 1'b0;
        step();
        chk("abort_ack", 32'(oWrAck), 32'd0);
        chk("abort_memEn", 32'(oMemEn), 32'd0);
        chk("abort_rgb", 32'(oRGB), 32'd0);
        chk("abort_errClr", 32'(oAddrErr), 32'd0);
        iRst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
